// File: rtl/mod20_run_ctrl.sv
// mod20_run_ctrl
// ----------------------------------------------------------------------------
// Run/pause/stop sequencer for the mod-20 counter datapath. It replaces the old
// free-running divided clock with a one-cycle count enable (cnt_tick) on the
// 50 MHz domain. It also handles button sequencing, count direction and tick-rate
// selection, plus an optional stop-at-target that reads the counter value back.
//
// Ports
//   clk_50M    in   system clock
//   reset      in   asynchronous, active-low reset
//   btn_start  in   async level; rising edge = start/resume command
//   btn_stop   in   async level; rising edge = pause/stop command
//   dir_sel    in   async; 1 = count up, 0 = count down
//   speed_sel  in   async; 1 = FAST_DIV, 0 = SLOW_DIV cycles per tick
//   target_en  in   enable stop-at-target
//   target     in   [4:0] target count value (>= MOD never matches)
//   count      in   [4:0] counter value fed back from the mod-20 counter
//   cnt_tick   out  one-cycle count enable
//   cnt_up     out  count direction, valid whenever cnt_tick=1
//   cnt_clr    out  one-cycle synchronous clear to the counter
//   state      out  [1:0] 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   done       out  high while in DONE (auto-reload build: one-cycle pulse)
//
// Build option
//   MOD20_RUN_CTRL_AUTORELOAD_EN: a target match clears the counter and keeps
//   running instead of entering DONE. done then pulses for the cycle in which
//   cnt_clr is high.
// ----------------------------------------------------------------------------
module mod20_run_ctrl #(
  parameter int unsigned FAST_DIV = 5000000,
  parameter int unsigned SLOW_DIV = 50000000,
  parameter int unsigned MOD      = 20
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       dir_sel,
  input  logic       speed_sel,
  input  logic       target_en,
  input  logic [4:0] target,
  input  logic [4:0] count,
  output logic       cnt_tick,
  output logic       cnt_up,
  output logic       cnt_clr,
  output logic [1:0] state,
  output logic       done
);

  localparam int unsigned MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
  localparam int unsigned PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [PW-1:0] FAST_LIM = PW'(FAST_DIV - 1);
  localparam logic [PW-1:0] SLOW_LIM = PW'(SLOW_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // Synchronizers: bit order {speed_sel, dir_sel, btn_stop, btn_start}
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [1:0] prev_q;    // previous synced {stop, start} for edge detection

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {speed_sel, dir_sel, btn_stop, btn_start};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q[1:0];
    end
  end

  logic start_rise;
  logic stop_rise;
  logic dir_up_s;
  logic speed_fast_s;

  assign start_rise   = sync2_q[0] & ~prev_q[0];
  assign stop_rise    = sync2_q[1] & ~prev_q[1];
  assign dir_up_s     = sync2_q[2];
  assign speed_fast_s = sync2_q[3];

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          clr_q, clr_d;
  logic          up_q;
  logic          done_q, done_d;
  logic          tick_d1_q;   // a tick went out last cycle: count is fresh now

  logic [PW-1:0] div_lim;
  logic          target_ok;
  logic          target_hit;

  // The compare is >= so a SLOW->FAST switch with a large prescaler value
  // fires on the next cycle instead of wrapping through the full range.
  assign div_lim    = speed_fast_s ? FAST_LIM : SLOW_LIM;
  assign target_ok  = (32'(target) < MOD);
  assign target_hit = tick_d1_q & target_en & target_ok & (count == target);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A stop edge is meaningless here, and it also masks a coincident start.
        if (start_rise && !stop_rise) begin
          state_d = ST_RUN;
          clr_d   = 1'b1;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        if (stop_rise) begin
          state_d = ST_PAUSE;           // prescaler held for resume
        end else if (target_hit) begin
`ifdef MOD20_RUN_CTRL_AUTORELOAD_EN
          clr_d   = 1'b1;
          presc_d = '0;
          done_d  = 1'b1;
`else
          state_d = ST_DONE;
`endif
        end else if (presc_q >= div_lim) begin
          tick_d  = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (stop_rise) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
          presc_d = '0;
        end else if (start_rise) begin
          state_d = ST_RUN;             // resume from held prescaler
        end
      end
      default: begin                    // ST_DONE
        if (stop_rise) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
          presc_d = '0;
        end else if (start_rise) begin
          state_d = ST_RUN;
          clr_d   = 1'b1;
          presc_d = '0;
        end
      end
    endcase
`ifndef MOD20_RUN_CTRL_AUTORELOAD_EN
    done_d = (state_d == ST_DONE);
`endif
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      clr_q     <= 1'b0;
      up_q      <= 1'b1;
      done_q    <= 1'b0;
      tick_d1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      clr_q     <= clr_d;
      up_q      <= dir_up_s;
      done_q    <= done_d;
      tick_d1_q <= tick_q;
    end
  end

  assign cnt_tick = tick_q;
  assign cnt_clr  = clr_q;
  assign cnt_up   = up_q;
  assign state    = state_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mod20_run_ctrl.sv
// Bench for mod20_run_ctrl with FAST_DIV=4, SLOW_DIV=10. A mod-20 counter
// driven by cnt_tick/cnt_clr/cnt_up feeds count back. A behavioural model
// predicts every output each cycle. Directed sequences add literal expectations.
module tb_mod20_run_ctrl;

  localparam int unsigned FAST = 4;
  localparam int unsigned SLOW = 10;
  localparam int unsigned MODV = 20;
`ifdef MOD20_RUN_CTRL_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_stop  = 1'b0;
  logic       dir_sel   = 1'b1;
  logic       speed_sel = 1'b1;
  logic       target_en = 1'b0;
  logic [4:0] target    = 5'd0;
  logic [4:0] count;
  logic       cnt_tick, cnt_up, cnt_clr, done;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  mod20_run_ctrl #(.FAST_DIV(FAST), .SLOW_DIV(SLOW), .MOD(MODV)) dut (
    .clk_50M  (clk),
    .reset    (reset),
    .btn_start(btn_start),
    .btn_stop (btn_stop),
    .dir_sel  (dir_sel),
    .speed_sel(speed_sel),
    .target_en(target_en),
    .target   (target),
    .count    (count),
    .cnt_tick (cnt_tick),
    .cnt_up   (cnt_up),
    .cnt_clr  (cnt_clr),
    .state    (state),
    .done     (done)
  );

  always #5 clk = ~clk;

  // The external mod-20 counter
  always @(posedge clk or negedge reset) begin
    if (!reset)        count <= 5'd0;
    else if (cnt_clr)  count <= 5'd0;
    else if (cnt_tick) count <= cnt_up ? ((count == 5'd19) ? 5'd0 : count + 5'd1)
                                       : ((count == 5'd0) ? 5'd19 : count - 5'd1);
  end

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw inputs are seen through a 3-deep history: entry [1] is what the
  // synchronizer presents at this edge, entry [2] the value one edge before.
  int m_mode, m_elapsed, m_count, m_div;
  bit m_tick, m_clr, m_up, m_done, m_fresh;
  bit se, pe, hit, nt, nc, np;
  bit h_start[3], h_stop[3], h_dir[3], h_spd[3];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_elapsed = 0; m_count = 0;
      m_tick = 0; m_clr = 0; m_up = 1; m_done = 0; m_fresh = 0;
      for (int i = 0; i < 3; i++) begin
        h_start[i] = 0; h_stop[i] = 0; h_dir[i] = 0; h_spd[i] = 0;
      end
    end else begin
      se    = h_start[1] && !h_start[2];
      pe    = h_stop[1] && !h_stop[2];
      m_div = h_spd[1] ? FAST : SLOW;
      hit   = m_fresh && target_en && (int'(target) < MODV) && (m_count == int'(target));
      // counter follows the pulses that were visible during the cycle just ended
      if (m_clr)       m_count = 0;
      else if (m_tick) m_count = (m_count + (m_up ? 1 : MODV - 1)) % MODV;
      m_fresh = m_tick;
      nt = 0; nc = 0; np = 0;
      case (m_mode)
        0: if (se && !pe) begin m_mode = 1; nc = 1; m_elapsed = 0; end
        1: begin
          if (pe) m_mode = 2;
          else if (hit) begin
            if (AR) begin nc = 1; np = 1; m_elapsed = 0; end
            else m_mode = 3;
          end else begin
            m_elapsed++;
            if (m_elapsed >= m_div) begin nt = 1; m_elapsed = 0; end
          end
        end
        2: if (pe) begin m_mode = 0; nc = 1; m_elapsed = 0; end
           else if (se) m_mode = 1;
        default: if (pe) begin m_mode = 0; nc = 1; m_elapsed = 0; end
                 else if (se) begin m_mode = 1; nc = 1; m_elapsed = 0; end
      endcase
      m_tick = nt;
      m_clr  = nc;
      m_done = AR ? np : (m_mode == 3);
      m_up   = h_dir[1];
      for (int i = 2; i > 0; i--) begin
        h_start[i] = h_start[i-1]; h_stop[i] = h_stop[i-1];
        h_dir[i]   = h_dir[i-1];   h_spd[i]  = h_spd[i-1];
      end
      h_start[0] = btn_start; h_stop[0] = btn_stop;
      h_dir[0]   = dir_sel;   h_spd[0]  = speed_sel;
    end
  end

  always @(negedge clk) begin
    chkv("cmp_state", 32'(state), 32'(m_mode));
    chkv("cmp_tick", 32'(cnt_tick), 32'(m_tick));
    chkv("cmp_clr", 32'(cnt_clr), 32'(m_clr));
    chkv("cmp_done", 32'(done), 32'(m_done));
    chkv("cmp_count", 32'(count), 32'(m_count));
    chkv("cmp_tick_clr_excl", 32'(cnt_tick & cnt_clr), 32'd0);
    if (m_tick) chkv("cmp_up", 32'(cnt_up), 32'(m_up));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic press(input bit s, input bit p);
    btn_start = s; btn_stop = p;
    step(1);
    btn_start = 1'b0; btn_stop = 1'b0;
  endtask

  task automatic wait_tick(input int lim);
    int n;
    n = 0;
    do begin step(1); n++; end while (cnt_tick !== 1'b1 && n < lim);
    chkv("wait_tick", 32'(cnt_tick), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, i_cnt5, i_done;
    step(3);
    chkv("rst_state", 32'(state), 32'd0);
    chkv("rst_tick", 32'(cnt_tick), 32'd0);
    chkv("rst_clr", 32'(cnt_clr), 32'd0);
    chkv("rst_done", 32'(done), 32'd0);
    chkv("rst_up", 32'(cnt_up), 32'd1);
    reset = 1'b1;
    step(4);

    // Start, fast, up: clear 3 cycles after the edge, ticks every 4
    btn_start = 1'b1; step(1); btn_start = 1'b0;
    chkv("s_clr_l1", 32'(cnt_clr), 32'd0);
    step(1); chkv("s_clr_l2", 32'(cnt_clr), 32'd0); chkv("s_state_l2", 32'(state), 32'd0);
    step(1); chkv("s_clr", 32'(cnt_clr), 32'd1); chkv("s_state", 32'(state), 32'd1);
    step(1); chkv("s_clr_off", 32'(cnt_clr), 32'd0); chkv("s_cnt0", 32'(count), 32'd0);
    step(3); chkv("s_tick1", 32'(cnt_tick), 32'd1); chkv("s_up1", 32'(cnt_up), 32'd1);
    step(1); chkv("s_cnt1", 32'(count), 32'd1); chkv("s_tick1_off", 32'(cnt_tick), 32'd0);
    step(3); chkv("s_tick2", 32'(cnt_tick), 32'd1);
    step(1); chkv("s_cnt2", 32'(count), 32'd2);
    step(3); chkv("s_tick3", 32'(cnt_tick), 32'd1);
    step(1); chkv("s_cnt3", 32'(count), 32'd3);

    // Asynchronous reset mid-run with prescaler at 3
    step(2);
    reset = 1'b0; #1;
    chkv("ar_state", 32'(state), 32'd0);
    chkv("ar_tick", 32'(cnt_tick), 32'd0);
    chkv("ar_clr", 32'(cnt_clr), 32'd0);
    chkv("ar_done", 32'(done), 32'd0);
    step(2); reset = 1'b1;
    ticks = 0;
    repeat (20) begin step(1); if (cnt_tick === 1'b1) ticks++; end
    chkv("ar_idle_ticks", 32'(ticks), 32'd0);
    chkv("ar_idle_state", 32'(state), 32'd0);

    // Pause/resume: stop right after a tick holds prescaler 2 -> resume gap 2
    press(1, 0); step(2); chkv("p_run", 32'(state), 32'd1);
    wait_tick(20);
    press(0, 1); step(2); chkv("p_pause", 32'(state), 32'd2);
    ticks = 0;
    repeat (50) begin step(1); if (cnt_tick === 1'b1) ticks++; end
    chkv("p_no_ticks", 32'(ticks), 32'd0);
    chkv("p_still_pause", 32'(state), 32'd2);
    press(1, 0); step(2); chkv("p_resume", 32'(state), 32'd1);
    step(1); chkv("p_gap1", 32'(cnt_tick), 32'd0);
    step(1); chkv("p_gap2_tick", 32'(cnt_tick), 32'd1);
    press(0, 1); step(2); chkv("p_pause2", 32'(state), 32'd2);
    press(0, 1); step(2);
    chkv("p_stop_clr", 32'(cnt_clr), 32'd1);
    chkv("p_stop_idle", 32'(state), 32'd0);

    // Target 5, counting up
    target = 5'd5; target_en = 1'b1; step(1);
    press(1, 0); step(2); chkv("t_clr", 32'(cnt_clr), 32'd1);
    ticks = 0; i_cnt5 = -1; i_done = -1;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (cnt_tick === 1'b1) ticks++;
      if (count == 5'd5 && i_cnt5 < 0) i_cnt5 = i;
`ifdef MOD20_RUN_CTRL_AUTORELOAD_EN
      if (done === 1'b1) begin i_done = i; break; end
`else
      if (state === 2'b11) begin i_done = i; break; end
`endif
    end
    chkv("t_ticks", 32'(ticks), 32'd5);
    chkv("t_done_lag", 32'(i_done - i_cnt5), 32'd1);
    chkv("t_count", 32'(count), 32'd5);
    chkv("t_done", 32'(done), 32'd1);
`ifndef MOD20_RUN_CTRL_AUTORELOAD_EN
    chkv("t_state_done", 32'(state), 32'd3);
    ticks = 0;
    repeat (30) begin step(1); if (cnt_tick === 1'b1) ticks++; end
    chkv("t_quiet", 32'(ticks), 32'd0);
    chkv("t_done_level", 32'(done), 32'd1);
`endif
    press(0, 1); step(2); press(0, 1); step(2);
    chkv("t_back_idle", 32'(state), 32'd0);

    // Target 25 is out of range: 25 ticks wrap the counter to 5 with no stop
    target = 5'd25; step(1);
    press(1, 0); step(2); chkv("t25_clr", 32'(cnt_clr), 32'd1);
    repeat (25) wait_tick(10);
    step(1);
    chkv("t25_count", 32'(count), 32'd5);
    chkv("t25_state", 32'(state), 32'd1);

    // Simultaneous start+stop in RUN -> PAUSE; then SLOW->FAST at prescaler 7
    press(1, 1); step(2); chkv("ss_pause", 32'(state), 32'd2);
    speed_sel = 1'b0; step(3);
    press(1, 0); step(2); chkv("sp_run", 32'(state), 32'd1);
    wait_tick(20);
    step(7); speed_sel = 1'b1;
    step(3); chkv("sp_tick_a", 32'(cnt_tick), 32'd1);
    step(3); chkv("sp_gap", 32'(cnt_tick), 32'd0);
    step(1); chkv("sp_tick_b", 32'(cnt_tick), 32'd1);

    // Target 3 counting down from 0: 19,18,...,3 is 17 ticks
    press(0, 1); step(2); press(0, 1); step(2);
    chkv("d_idle", 32'(state), 32'd0);
    dir_sel = 1'b0; target = 5'd3; target_en = 1'b1; step(3);
    press(1, 0); step(2); chkv("d_clr", 32'(cnt_clr), 32'd1);
    ticks = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (cnt_tick === 1'b1) ticks++;
`ifdef MOD20_RUN_CTRL_AUTORELOAD_EN
      if (done === 1'b1) break;
`else
      if (state === 2'b11) break;
`endif
    end
    chkv("d_ticks", 32'(ticks), 32'd17);
`ifdef MOD20_RUN_CTRL_AUTORELOAD_EN
    chkv("d_reload_clr", 32'(cnt_clr), 32'd1);
    chkv("d_reload_state", 32'(state), 32'd1);
    step(1);
    chkv("d_done_pulse_end", 32'(done), 32'd0);
    chkv("d_count_zero", 32'(count), 32'd0);
    wait_tick(10); step(1);
    chkv("d_count_19", 32'(count), 32'd19);
`else
    chkv("d_done", 32'(done), 32'd1);
    chkv("d_count", 32'(count), 32'd3);
    press(1, 0); step(2);
    chkv("d_restart_clr", 32'(cnt_clr), 32'd1);
    chkv("d_restart_run", 32'(state), 32'd1);
`endif
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
